// File: rtl/hook_pkg.sv
// Shared types and constants for the GoldMiner hook controller.
// Holds the FSM state encoding, object weight codes, retract speed table,
// default geometry/border constants and the direction LUT magnitude helpers.
package hook_pkg;

  localparam int unsigned ANGLE_W   = 5;
  localparam int unsigned LEN_W     = 10;
  localparam int unsigned LEN_EXT_W = 11;
  localparam int unsigned ROPE_W    = 11;
  localparam int unsigned TIP_W     = 12;
  localparam int unsigned PROD_W    = 18;
  localparam int unsigned TICK_W    = 4;
  localparam int unsigned SPD_W     = 4;
  localparam int unsigned BLKX_W    = 11;
  localparam int unsigned BLKY_W    = 10;
  localparam int unsigned VALUE_W   = 10;

  localparam int unsigned ANGLE_MID = 8;
  localparam int unsigned ANGLE_MAX = 16;

  localparam int unsigned DEF_PIVOT_X   = 635;
  localparam int unsigned DEF_PIVOT_Y   = 167;
  localparam int unsigned DEF_L0        = 24;
  localparam int unsigned DEF_SWING_DIV = 2;
  localparam int unsigned DEF_SPEED_EXT = 4;
  localparam int unsigned DEF_X_MIN     = 10;
  localparam int unsigned DEF_X_MAX     = 1269;
  localparam int unsigned DEF_Y_MAX     = 789;
  localparam int unsigned DEF_LEN_MAX   = 1000;

  // Sprite is drawn with its left edge this far left of the tip.
  localparam int unsigned BLK_X_OFS = 10;

  typedef enum logic [2:0] {
    ST_SWING   = 3'd0,
    ST_EXTEND  = 3'd1,
    ST_RETRACT = 3'd2,
    ST_COLLECT = 3'd3,
    ST_HALT    = 3'd4
  } hook_state_e;

  localparam logic [1:0] WT_DIAMOND = 2'd0;
  localparam logic [1:0] WT_GOLD    = 2'd1;
  localparam logic [1:0] WT_STONE   = 2'd2;

  localparam logic [SPD_W-1:0] SPD_EMPTY   = 4'd8;
  localparam logic [SPD_W-1:0] SPD_DIAMOND = 4'd6;
  localparam logic [SPD_W-1:0] SPD_GOLD    = 4'd3;
  localparam logic [SPD_W-1:0] SPD_STONE   = 4'd1;

  // Retract speed in pixels per frame; the unused weight code pulls like stone.
  function automatic logic [SPD_W-1:0] retract_spd(input logic grab,
                                                    input logic [1:0] wt);
    if (!grab) begin
      retract_spd = SPD_EMPTY;
    end else begin
      case (wt)
        WT_DIAMOND: retract_spd = SPD_DIAMOND;
        WT_GOLD:    retract_spd = SPD_GOLD;
        default:    retract_spd = SPD_STONE;
      endcase
    end
  endfunction

  // |dx| in 1/16 pixel for |angle-8| = k (10 degree steps).
  function automatic logic [4:0] dx_mag(input logic [3:0] k);
    case (k)
      4'd0:    dx_mag = 5'd0;
      4'd1:    dx_mag = 5'd3;
      4'd2:    dx_mag = 5'd5;
      4'd3:    dx_mag = 5'd8;
      4'd4:    dx_mag = 5'd10;
      4'd5:    dx_mag = 5'd12;
      4'd6:    dx_mag = 5'd14;
      4'd7:    dx_mag = 5'd15;
      4'd8:    dx_mag = 5'd16;
      default: dx_mag = 5'd0;
    endcase
  endfunction

  // dy in 1/16 pixel for |angle-8| = k; always pointing down.
  function automatic logic [4:0] dy_mag(input logic [3:0] k);
    case (k)
      4'd0:    dy_mag = 5'd16;
      4'd1:    dy_mag = 5'd16;
      4'd2:    dy_mag = 5'd15;
      4'd3:    dy_mag = 5'd14;
      4'd4:    dy_mag = 5'd12;
      4'd5:    dy_mag = 5'd10;
      4'd6:    dy_mag = 5'd8;
      4'd7:    dy_mag = 5'd5;
      4'd8:    dy_mag = 5'd3;
      default: dy_mag = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/hook_dir_lut.sv
// Hook direction lookup: swing angle index -> signed unit vector (1/16 px).
// Ports: angle [4:0] in (0..16, 8 = straight down); dx, dy signed [5:0] out.
module hook_dir_lut
  import hook_pkg::*;
(
  input  logic [ANGLE_W-1:0] angle,
  output logic signed [5:0]  dx,
  output logic signed [5:0]  dy
);

  logic       left;
  logic [3:0] k;
  logic [4:0] dxm;

  // Fold the angle around vertical; the left half mirrors dx.
  always_comb begin
    left = (angle < ANGLE_W'(ANGLE_MID));
    k    = left ? 4'(ANGLE_W'(ANGLE_MID) - angle) : 4'(angle - ANGLE_W'(ANGLE_MID));
    dxm  = dx_mag(k);
    dx   = left ? -$signed({1'b0, dxm}) : $signed({1'b0, dxm});
    dy   = $signed({1'b0, dy_mag(k)});
  end

endmodule

// File: rtl/hook_ctrl.sv
// GoldMiner hook/rope sequencer: swing, fire, extend, retract, collect.
// Ports: clk, rst_n (sync, active-low); frame_tick, fire, hit, hit_weight,
// hit_value, done_game in; blkpos_x/blkpos_y (hook sprite position), state,
// grabbing, collect (one-cycle pulse), collect_value out. All outputs registered.
module hook_ctrl
  import hook_pkg::*;
#(
  parameter int unsigned PIVOT_X   = DEF_PIVOT_X,
  parameter int unsigned PIVOT_Y   = DEF_PIVOT_Y,
  parameter int unsigned L0        = DEF_L0,
  parameter int unsigned SWING_DIV = DEF_SWING_DIV,
  parameter int unsigned SPEED_EXT = DEF_SPEED_EXT,
  parameter int unsigned X_MIN     = DEF_X_MIN,
  parameter int unsigned X_MAX     = DEF_X_MAX,
  parameter int unsigned Y_MAX     = DEF_Y_MAX,
  parameter int unsigned LEN_MAX   = DEF_LEN_MAX
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_tick,
  input  logic                fire,
  input  logic                hit,
  input  logic [1:0]          hit_weight,
  input  logic [VALUE_W-1:0]  hit_value,
  input  logic                done_game,
  output logic [BLKX_W-1:0]   blkpos_x,
  output logic [BLKY_W-1:0]   blkpos_y,
  output logic [2:0]          state,
  output logic                grabbing,
  output logic                collect,
  output logic [VALUE_W-1:0]  collect_value
);

  hook_state_e          state_q, state_d;
  logic [ANGLE_W-1:0]   angle_q, angle_d;
  logic                 dir_up_q, dir_up_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic                 grabbing_q, grabbing_d;
  logic                 collect_q, collect_d;
  logic [VALUE_W-1:0]   collect_value_q, collect_value_d;
  logic [1:0]           weight_q, weight_d;
  logic [VALUE_W-1:0]   value_q, value_d;
  logic signed [TIP_W-1:0] tip_x_q, tip_x_d;
  logic signed [TIP_W-1:0] tip_y_q, tip_y_d;
  logic [BLKX_W-1:0]    blkpos_x_q, blkpos_x_d;
  logic [BLKY_W-1:0]    blkpos_y_q, blkpos_y_d;

  logic signed [5:0]    dx, dy;
  logic [ROPE_W-1:0]    rope;
  logic signed [PROD_W-1:0] sum_x, sum_y;
  logic                 border_c;
  logic [LEN_EXT_W-1:0] len_ext;
  logic [LEN_W-1:0]     len_ext_sat, len_ret;
  logic [SPD_W-1:0]     spd;
  logic [TICK_W-1:0]    tick_inc;
  logic [ANGLE_W-1:0]   angle_step;
  logic                 enter_collect;

  hook_dir_lut u_dir_lut (
    .angle (angle_q),
    .dx    (dx),
    .dy    (dy)
  );

  // Tip position from current angle/len; floor division by 16.
  always_comb begin
    rope       = ROPE_W'(L0) + ROPE_W'(len_q);
    sum_x      = $signed(PROD_W'(PIVOT_X * 16)) + PROD_W'(dx) * $signed({7'b0, rope});
    sum_y      = $signed(PROD_W'(PIVOT_Y * 16)) + PROD_W'(dy) * $signed({7'b0, rope});
    tip_x_d    = TIP_W'(sum_x >>> 4);
    tip_y_d    = TIP_W'(sum_y >>> 4);
    blkpos_x_d = BLKX_W'(tip_x_d - $signed(TIP_W'(BLK_X_OFS)));
    blkpos_y_d = BLKY_W'(tip_y_d);
  end

  // Border test uses the registered tip, i.e. what the renderer currently shows.
  always_comb begin
    border_c = (tip_x_q <= $signed(TIP_W'(X_MIN))) ||
               (tip_x_q >= $signed(TIP_W'(X_MAX))) ||
               (tip_y_q >= $signed(TIP_W'(Y_MAX)));
  end

  // Rope length arithmetic for extend (saturating) and retract (floor at 0).
  always_comb begin
    len_ext     = LEN_EXT_W'(len_q) + LEN_EXT_W'(SPEED_EXT);
    len_ext_sat = (len_ext > LEN_EXT_W'(LEN_MAX)) ? LEN_W'(LEN_MAX) : LEN_W'(len_ext);
    spd         = retract_spd(grabbing_q, weight_q);
    len_ret     = (len_q > LEN_W'(spd)) ? len_q - LEN_W'(spd) : '0;
    tick_inc    = tick_cnt_q + TICK_W'(1);
    angle_step  = dir_up_q ? angle_q + ANGLE_W'(1) : angle_q - ANGLE_W'(1);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d         = state_q;
    angle_d         = angle_q;
    dir_up_d        = dir_up_q;
    len_d           = len_q;
    tick_cnt_d      = tick_cnt_q;
    grabbing_d      = grabbing_q;
    collect_d       = 1'b0;
    collect_value_d = collect_value_q;
    weight_d        = weight_q;
    value_d         = value_q;
    enter_collect   = 1'b0;

    if (done_game) begin
      state_d    = ST_HALT;
      len_d      = '0;
      angle_d    = ANGLE_W'(ANGLE_MID);
      grabbing_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_SWING: begin
          if (fire) begin
            state_d = ST_EXTEND;
          end else if (frame_tick) begin
            if (tick_inc == TICK_W'(SWING_DIV)) begin
              tick_cnt_d = '0;
              angle_d    = angle_step;
              // Reverse at either end so the next step heads back.
              if (angle_step == ANGLE_W'(ANGLE_MAX)) begin
                dir_up_d = 1'b0;
              end else if (angle_step == '0) begin
                dir_up_d = 1'b1;
              end
            end else begin
              tick_cnt_d = tick_inc;
            end
          end
        end
        ST_EXTEND: begin
          // A grab wins over the border and freezes len for that cycle.
          if (hit) begin
            weight_d   = hit_weight;
            value_d    = hit_value;
            grabbing_d = 1'b1;
            state_d    = ST_RETRACT;
          end else if (frame_tick) begin
            if (border_c) begin
              state_d = ST_RETRACT;
            end else begin
              len_d = len_ext_sat;
            end
          end
        end
        ST_RETRACT: begin
          if (len_q == '0) begin
            enter_collect = 1'b1;
          end else if (frame_tick) begin
            len_d = len_ret;
            if (len_ret == '0) begin
              enter_collect = 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          grabbing_d = 1'b0;
          tick_cnt_d = '0;
          state_d    = ST_SWING;
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_SWING;
        end
      endcase
    end

    // Pulse is raised on entry so it is high exactly while state is COLLECT.
    if (enter_collect) begin
      state_d   = ST_COLLECT;
      collect_d = grabbing_q;
      if (grabbing_q) begin
        collect_value_d = value_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_SWING;
      angle_q         <= ANGLE_W'(ANGLE_MID);
      dir_up_q        <= 1'b1;
      len_q           <= '0;
      tick_cnt_q      <= '0;
      grabbing_q      <= 1'b0;
      collect_q       <= 1'b0;
      collect_value_q <= '0;
      weight_q        <= '0;
      value_q         <= '0;
      tip_x_q         <= TIP_W'(PIVOT_X);
      tip_y_q         <= TIP_W'(PIVOT_Y + L0);
      blkpos_x_q      <= BLKX_W'(PIVOT_X - BLK_X_OFS);
      blkpos_y_q      <= BLKY_W'(PIVOT_Y + L0);
    end else begin
      state_q         <= state_d;
      angle_q         <= angle_d;
      dir_up_q        <= dir_up_d;
      len_q           <= len_d;
      tick_cnt_q      <= tick_cnt_d;
      grabbing_q      <= grabbing_d;
      collect_q       <= collect_d;
      collect_value_q <= collect_value_d;
      weight_q        <= weight_d;
      value_q         <= value_d;
      tip_x_q         <= tip_x_d;
      tip_y_q         <= tip_y_d;
      blkpos_x_q      <= blkpos_x_d;
      blkpos_y_q      <= blkpos_y_d;
    end
  end

  assign blkpos_x      = blkpos_x_q;
  assign blkpos_y      = blkpos_y_q;
  assign state         = state_q;
  assign grabbing      = grabbing_q;
  assign collect       = collect_q;
  assign collect_value = collect_value_q;

endmodule
